vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator: H/V counters, hsync/vsync/blank, pixel coordinates.
//  Optional built-in test-pattern colour output.
//  Sits between the pixel clock and the DVI/TMDS encoder, or drives a VGA DAC directly.
//  Defaults give 640x480@60 (800x525 total, 25.2 MHz pixel clock).
//  Corrects the earlier generator's sync widths: hsync is a full 96 clocks, vsync a full 2 lines.
// PARAMETERS
//  H_VISIBLE  640  active pixels per line
//  H_FRONT    16   h front porch, clocks
//  H_SYNC     96   h sync width, clocks
//  H_BACK     48   h back porch, clocks
//  V_VISIBLE  480  active lines
//  V_FRONT    10   v front porch, lines
//  V_SYNC     2    v sync width, lines
//  V_BACK     33   v back porch, lines
//  HSYNC_POL  0    asserted level of hsync (0 = active-low)
//  VSYNC_POL  0    asserted level of vsync
//  COLOR_BITS 3    bits per colour channel
//  Derived: H_TOTAL = sum of the H_* parameters; V_TOTAL likewise.
//  Derived: HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).
// PORTS
//  clk          in   1           pixel clock
//  reset        in   1           asynchronous, active-high
//  enable       in   1           1 = advance raster; 0 = freeze counters and outputs
//  mode         in   2           test-pattern select, sampled at frame start
//  red          out  COLOR_BITS  red channel
//  green        out  COLOR_BITS  green channel
//  blue         out  COLOR_BITS  blue channel
//  hsync        out  1           horizontal sync, polarity per HSYNC_POL
//  vsync        out  1           vertical sync, polarity per VSYNC_POL
//  blank        out  1           1 outside the visible area
//  x            out  HW          current pixel column (hcount)
//  y            out  VW          current line (vcount)
//  line_start   out  1           1-cycle pulse at hcount == 0
//  frame_start  out  1           1-cycle pulse at hcount == 0 && vcount == 0
// BEHAVIOUR
//  Counters
//  - hcount: 0..H_TOTAL-1, wraps to 0.
//  - vcount: increments on h wrap; wraps to 0 at V_TOTAL-1 together with the h wrap.
//  - Both advance only while enable = 1.
//  Output timing
//  - Every output is registered, decoded from the current counter values.
//  - An output at edge n reflects the counters held before edge n: 1-cycle latency, all outputs aligned.
//  - hsync asserted iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
//  - vsync asserted iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC (lines 490..491).
//  - vsync changes at the hcount == 0 boundary.
//  - blank = (hcount >= H_VISIBLE) || (vcount >= V_VISIBLE).
//  - red/green/blue forced to 0 whenever blank is 1.
//  Reset (asynchronous)
//  - hcount = vcount = 0; x = y = 0.
//  - hsync = ~HSYNC_POL; vsync = ~VSYNC_POL; blank = 1; RGB = 0.
//  - line_start = frame_start = 0; active mode register = 0.
//  - Reset mid-frame aborts the frame; the first enabled edge after release shows pixel (0,0).
//  - That edge pulses frame_start and line_start.
//  Enable
//  - enable = 0 holds every output at its last value, including pulses.
//  - A pulse therefore stretches while enable = 0; consumers must qualify pulses with enable.
//  Mode
//  - mode is latched into the active register only on the edge that emits frame_start.
//  - A mid-frame change takes effect at the next frame, so a frame never tears.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: pattern generator compiled in, with all channels full-scale = all ones.
//  - mode 0: black.
//  - mode 1: solid magenta, red = blue = all ones, green = 0.
//  - mode 2: 8 vertical bars, each H_VISIBLE/8 wide.
//    - bar index b = x / (H_VISIBLE/8).
//    - red = {COLOR_BITS{b[2]}}, green = {COLOR_BITS{b[1]}}, blue = {COLOR_BITS{b[0]}}.
//  - mode 3: 32x32 checkerboard, white where x[5]^y[5], else black.
//  VGA_TEST_PATTERN_EN undefined: RGB tied to 0, mode ignored, no pattern logic synthesised.
//  - All timing outputs are identical with and without the macro.
// TESTING
//  1 Defaults, assert reset 5 cycles, release, enable=1 -> first edge: x=0, y=0, frame_start=1,
//    blank=0; hsync=1, vsync=1.
//  2 Run one line -> hsync low exactly at x=656..751 (96 clocks); blank high at x=640..799.
//    line_start period is exactly 800 clocks.
//  3 Run two frames -> vsync low for lines 490..491 (1600 clocks).
//    frame_start period is exactly 420000 clocks; y wraps 524 -> 0 with x 799 -> 0.
//  4 VGA_TEST_PATTERN_EN, mode=2 -> x=0: RGB=0/0/0; x=80: blue=7; x=560: R=G=B=7; x=640: all 0.
//    mode switched to 1 at y=100 -> pattern unchanged until the next frame_start, then magenta.
//  5 enable=0 for 37 cycles at x=300 -> x, y and all outputs frozen.
//    On resume, x=301 follows on the next enabled edge.
//  6 Reset at x=700, y=200, then release -> outputs return to reset values asynchronously.
//    Raster restarts at (0,0) with frame_start=1; H_VISIBLE=16 small-parameter run repeats 2/3.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video bus between the raster timing generator and its consumer (encoder, DAC or bench).
// The master side is the generator: it takes enable/mode and drives sync, blank, position and colour.
interface vga_timing_gen_if #(
   parameter int COLOR_BITS = 3,
   parameter int HW         = 10,
   parameter int VW         = 10
);
   logic                  enable;
   logic [1:0]            mode;
   logic [COLOR_BITS-1:0] red;
   logic [COLOR_BITS-1:0] green;
   logic [COLOR_BITS-1:0] blue;
   logic                  hsync;
   logic                  vsync;
   logic                  blank;
   logic [HW-1:0]         x;
   logic [VW-1:0]         y;
   logic                  line_start;
   logic                  frame_start;

   modport master (
      input  enable, mode,
      output red, green, blue, hsync, vsync, blank, x, y, line_start, frame_start
   );

   modport slave (
      output enable, mode,
      input  red, green, blue, hsync, vsync, blank, x, y, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: H/V counters, sync/blank, coordinates, all registered and aligned.
// Define VGA_TEST_PATTERN_EN to compile in the test-pattern colour generator; otherwise RGB is tied to 0.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int COLOR_BITS = 3
) (
   input logic              clk,
   input logic              reset,
   vga_timing_gen_if.master bus
);
   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [HW-1:0]         r_hcount;
   logic [VW-1:0]         r_vcount;
   logic [HW-1:0]         r_x;
   logic [VW-1:0]         r_y;
   logic                  r_hsync;
   logic                  r_vsync;
   logic                  r_blank;
   logic                  r_line_start;
   logic                  r_frame_start;
   logic [COLOR_BITS-1:0] r_red;
   logic [COLOR_BITS-1:0] r_green;
   logic [COLOR_BITS-1:0] r_blue;

   logic                  w_h_last;
   logic                  w_v_last;
   logic                  w_line;
   logic                  w_frame;
   logic                  w_hs_act;
   logic                  w_vs_act;
   logic                  w_blank;
   logic [COLOR_BITS-1:0] w_red;
   logic [COLOR_BITS-1:0] w_green;
   logic [COLOR_BITS-1:0] w_blue;

   // Decodes are compared at 32 bits so a sync end equal to 2**HW cannot alias.
   assign w_h_last = (r_hcount == HW'(H_TOTAL - 1));
   assign w_v_last = (r_vcount == VW'(V_TOTAL - 1));
   assign w_line   = (r_hcount == '0);
   assign w_frame  = w_line && (r_vcount == '0);
   assign w_hs_act = (32'(r_hcount) >= HS_START) && (32'(r_hcount) < HS_END);
   assign w_vs_act = (32'(r_vcount) >= VS_START) && (32'(r_vcount) < VS_END);
   assign w_blank  = (32'(r_hcount) >= H_VISIBLE) || (32'(r_vcount) >= V_VISIBLE);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;

   logic [1:0] r_mode;
   logic [1:0] w_mode;
   logic [2:0] w_bar;
   logic       w_chk;

   // The first pixel of a frame already uses the newly latched mode, so no frame mixes two patterns.
   assign w_mode = w_frame ? bus.mode : r_mode;
   assign w_bar  = 3'(32'(r_hcount) / BAR_W);
   assign w_chk  = 1'((32'(r_hcount) ^ 32'(r_vcount)) >> 5);

   always_comb begin
      w_red   = '0;
      w_green = '0;
      w_blue  = '0;
      if (!w_blank) begin
         case (w_mode)
            2'd1: begin
               w_red  = '1;
               w_blue = '1;
            end
            2'd2: begin
               w_red   = {COLOR_BITS{w_bar[2]}};
               w_green = {COLOR_BITS{w_bar[1]}};
               w_blue  = {COLOR_BITS{w_bar[0]}};
            end
            2'd3: begin
               w_red   = {COLOR_BITS{w_chk}};
               w_green = {COLOR_BITS{w_chk}};
               w_blue  = {COLOR_BITS{w_chk}};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_mode <= '0;
      else if (bus.enable && w_frame)
         r_mode <= bus.mode;
   end
`else
   logic [1:0] w_unused_mode;

   assign w_unused_mode = bus.mode;
   assign w_red         = '0;
   assign w_green       = '0;
   assign w_blue        = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_blank       <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_red         <= '0;
         r_green       <= '0;
         r_blue        <= '0;
      end else if (bus.enable) begin
         r_hcount <= w_h_last ? '0 : r_hcount + 1'b1;
         if (w_h_last)
            r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
         r_x           <= r_hcount;
         r_y           <= r_vcount;
         r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
         r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
         r_blank       <= w_blank;
         r_line_start  <= w_line;
         r_frame_start <= w_frame;
         r_red         <= w_red;
         r_green       <= w_green;
         r_blue        <= w_blue;
      end
   end

   assign bus.x           = r_x;
   assign bus.y           = r_y;
   assign bus.hsync       = r_hsync;
   assign bus.vsync       = r_vsync;
   assign bus.blank       = r_blank;
   assign bus.line_start  = r_line_start;
   assign bus.frame_start = r_frame_start;
   assign bus.red         = r_red;
   assign bus.green       = r_green;
   assign bus.blue        = r_blue;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance and a default 640x480 instance share clock,
// reset, enable and mode; a position-arithmetic model is compared every cycle, plus literal spot checks.
module tb_vga_timing_gen;
   localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 3;
   localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 2;
   localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
   localparam int D_VV = 480, D_VF = 10, D_VS = 2, D_VB = 33;
   localparam int FR_S = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
   localparam int FR_D = (D_HV + D_HF + D_HS + D_HB) * (D_VV + D_VF + D_VS + D_VB);
`ifdef VGA_TEST_PATTERN_EN
   localparam bit PAT = 1'b1;
`else
   localparam bit PAT = 1'b0;
`endif

   typedef struct {
      int x; int y; int r; int g; int b;
      bit hs; bit vs; bit bl; bit ls; bit fs;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   int         n_checks = 0;
   int         n_errors = 0;

   vga_timing_gen_if #(.COLOR_BITS(3), .HW(5),  .VW(4))  s_bus ();
   vga_timing_gen_if #(.COLOR_BITS(3), .HW(10), .VW(10)) d_bus ();

   assign s_bus.enable = enable;
   assign s_bus.mode   = mode;
   assign d_bus.enable = enable;
   assign d_bus.mode   = mode;

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_BITS(3)
   ) u_small (.clk(clk), .reset(reset), .bus(s_bus));

   vga_timing_gen u_dflt (.clk(clk), .reset(reset), .bus(d_bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the k-th enabled edge since reset: position is plain division of k.
   function automatic exp_t decode(int k, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb, int am);
      exp_t e;
      int ht, vt, h, v, bar, full;
      ht = hv + hf + hs + hb;
      vt = vv + vf + vs + vb;
      h = k % ht;
      v = (k / ht) % vt;
      full = 7;
      e.x  = h;
      e.y  = v;
      e.hs = !(h >= hv + hf && h < hv + hf + hs);
      e.vs = !(v >= vv + vf && v < vv + vf + vs);
      e.bl = (h >= hv) || (v >= vv);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      e.r = 0; e.g = 0; e.b = 0;
      if (PAT && !e.bl) begin
         if (am == 1) begin
            e.r = full; e.b = full;
         end else if (am == 2) begin
            bar = h / (hv / 8);
            e.r = (bar / 4) % 2 == 1 ? full : 0;
            e.g = (bar / 2) % 2 == 1 ? full : 0;
            e.b = bar % 2 == 1 ? full : 0;
         end else if (am == 3) begin
            e.r = ((h / 32) + (v / 32)) % 2 == 1 ? full : 0;
            e.g = e.r; e.b = e.r;
         end
      end
      return e;
   endfunction

   function automatic exp_t rst_exp();
      exp_t e;
      e.x = 0; e.y = 0; e.r = 0; e.g = 0; e.b = 0;
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
      return e;
   endfunction

   task automatic cmp(string p, exp_t e, int x, int y, int hs, int vs, int bl,
                      int ls, int fs, int r, int g, int b);
      chk({p, "_x"}, x, e.x);
      chk({p, "_y"}, y, e.y);
      chk({p, "_hsync"}, hs, int'(e.hs));
      chk({p, "_vsync"}, vs, int'(e.vs));
      chk({p, "_blank"}, bl, int'(e.bl));
      chk({p, "_line_start"}, ls, int'(e.ls));
      chk({p, "_frame_start"}, fs, int'(e.fs));
      chk({p, "_red"}, r, e.r);
      chk({p, "_green"}, g, e.g);
      chk({p, "_blue"}, b, e.b);
   endtask

   // Model and compare process: inputs are sampled at the edge, outputs checked 1 time unit later.
   int   m_k = 0;
   int   m_am_s = 0;
   int   m_am_d = 0;
   bit   m_valid = 1'b0;
   exp_t m_es;
   exp_t m_ed;

   always @(posedge clk) begin
      if (reset) begin
         m_k = 0; m_am_s = 0; m_am_d = 0; m_valid = 1'b1;
         m_es = rst_exp();
         m_ed = rst_exp();
      end else if (enable && m_valid) begin
         if (m_k % FR_S == 0) m_am_s = int'(mode);
         if (m_k % FR_D == 0) m_am_d = int'(mode);
         m_es = decode(m_k, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, m_am_s);
         m_ed = decode(m_k, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB, m_am_d);
         m_k++;
      end
      #1;
      if (m_valid) begin
         cmp("s", m_es, int'(s_bus.x), int'(s_bus.y), int'(s_bus.hsync), int'(s_bus.vsync),
             int'(s_bus.blank), int'(s_bus.line_start), int'(s_bus.frame_start),
             int'(s_bus.red), int'(s_bus.green), int'(s_bus.blue));
         cmp("d", m_ed, int'(d_bus.x), int'(d_bus.y), int'(d_bus.hsync), int'(d_bus.vsync),
             int'(d_bus.blank), int'(d_bus.line_start), int'(d_bus.frame_start),
             int'(d_bus.red), int'(d_bus.green), int'(d_bus.blue));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(string p, int x, int y, int hs, int vs, int bl, int ls,
                                 int fs, int rgb);
      chk({p, "_rst_x"}, x, 0);
      chk({p, "_rst_y"}, y, 0);
      chk({p, "_rst_hsync"}, hs, 1);
      chk({p, "_rst_vsync"}, vs, 1);
      chk({p, "_rst_blank"}, bl, 1);
      chk({p, "_rst_line_start"}, ls, 0);
      chk({p, "_rst_frame_start"}, fs, 0);
      chk({p, "_rst_rgb"}, rgb, 0);
   endtask

   initial begin
      int found, hs_low, bl_hi, first_hs, extra, vs_low;
      reset = 1'b1; enable = 1'b0; mode = 2'd2;
      repeat (5) @(posedge clk);
      #1;
      chk_reset_vals("s", int'(s_bus.x), int'(s_bus.y), int'(s_bus.hsync), int'(s_bus.vsync),
                     int'(s_bus.blank), int'(s_bus.line_start), int'(s_bus.frame_start),
                     int'({s_bus.red, s_bus.green, s_bus.blue}));
      #1;
      reset = 1'b0; enable = 1'b1;
      tick();
      chk("first_x", int'(s_bus.x), 0);
      chk("first_y", int'(s_bus.y), 0);
      chk("first_frame_start", int'(s_bus.frame_start), 1);
      chk("first_line_start", int'(s_bus.line_start), 1);
      chk("first_blank", int'(s_bus.blank), 0);
      chk("first_hsync", int'(s_bus.hsync), 1);
      chk("first_vsync", int'(s_bus.vsync), 1);
      chk("first_d_frame_start", int'(d_bus.frame_start), 1);

      // Freeze for 37 cycles while the default raster shows x=300.
      found = 0;
      for (int i = 0; i < 1000 && found == 0; i++)
         if (int'(d_bus.x) == 300) found = 1; else tick();
      chk("reach_x300", found, 1);
      enable = 1'b0;
      repeat (37) tick();
      chk("freeze_x", int'(d_bus.x), 300);
      chk("freeze_y", int'(d_bus.y), 0);
      enable = 1'b1;
      tick();
      chk("resume_x", int'(d_bus.x), 301);

      // One full default line starting at line_start.
      found = 0;
      for (int i = 0; i < 1000 && found == 0; i++)
         if (d_bus.line_start) found = 1; else tick();
      chk("reach_line", found, 1);
      hs_low = 0; bl_hi = 0; first_hs = -1; extra = 0;
      for (int i = 0; i < 800; i++) begin
         if (!d_bus.hsync) begin
            hs_low++;
            if (first_hs < 0) first_hs = int'(d_bus.x);
         end
         if (d_bus.blank) bl_hi++;
         if (i > 0 && d_bus.line_start) extra++;
`ifdef VGA_TEST_PATTERN_EN
         if (int'(d_bus.x) == 0)
            chk("bar0_rgb", int'({d_bus.red, d_bus.green, d_bus.blue}), 0);
         if (int'(d_bus.x) == 80)
            chk("bar1_rgb", int'({d_bus.red, d_bus.green, d_bus.blue}), 9'o007);
         if (int'(d_bus.x) == 560)
            chk("bar7_rgb", int'({d_bus.red, d_bus.green, d_bus.blue}), 9'o777);
         if (int'(d_bus.x) == 640)
            chk("bar_blank_rgb", int'({d_bus.red, d_bus.green, d_bus.blue}), 0);
`else
         if (int'(d_bus.x) == 80)
            chk("rgb_tied_off", int'({d_bus.red, d_bus.green, d_bus.blue}), 0);
`endif
         tick();
      end
      chk("line_hsync_low", hs_low, 96);
      chk("line_hsync_first", first_hs, 656);
      chk("line_blank_high", bl_hi, 160);
      chk("line_extra_pulses", extra, 0);
      chk("line_period", int'(d_bus.line_start), 1);

      // One full small frame starting at frame_start.
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++)
         if (s_bus.frame_start) found = 1; else tick();
      chk("reach_frame", found, 1);
      vs_low = 0; extra = 0;
      for (int i = 0; i < FR_S; i++) begin
         if (!s_bus.vsync) vs_low++;
         if (i > 0 && s_bus.frame_start) extra++;
         if (i == FR_S - 1) begin
            chk("frame_last_x", int'(s_bus.x), 23);
            chk("frame_last_y", int'(s_bus.y), 12);
         end
         tick();
      end
      chk("frame_vsync_low", vs_low, 48);
      chk("frame_extra_pulses", extra, 0);
      chk("frame_period", int'(s_bus.frame_start), 1);
      chk("frame_wrap_x", int'(s_bus.x), 0);
      chk("frame_wrap_y", int'(s_bus.y), 0);

      // Random enable gaps and mode changes; the model tracks when each mode takes effect.
      for (int i = 0; i < 1500; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         tick();
      end
      enable = 1'b1;

      // Asynchronous reset mid-line on the default raster.
      found = 0;
      for (int i = 0; i < 900 && found == 0; i++)
         if (int'(d_bus.x) == 700) found = 1; else tick();
      chk("reach_x700", found, 1);
      #1;
      reset = 1'b1;
      #1;
      chk_reset_vals("d", int'(d_bus.x), int'(d_bus.y), int'(d_bus.hsync), int'(d_bus.vsync),
                     int'(d_bus.blank), int'(d_bus.line_start), int'(d_bus.frame_start),
                     int'({d_bus.red, d_bus.green, d_bus.blue}));
      chk("async_s_blank", int'(s_bus.blank), 1);
      repeat (3) tick();
      #1;
      reset = 1'b0;
      tick();
      chk("restart_d_frame_start", int'(d_bus.frame_start), 1);
      chk("restart_d_line_start", int'(d_bus.line_start), 1);
      chk("restart_d_x", int'(d_bus.x), 0);
      chk("restart_s_frame_start", int'(s_bus.frame_start), 1);

      for (int i = 0; i < 400; i++) begin
         enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end
endmodule
